// File: rtl/hole_selector.sv
// hole_selector
//   Pocket-call controller. While the game holds selectEnable, the player
//   moves a cursor over pockets 1..6 with next/prev keys. The cursor is
//   locked by confirm or by a frame timeout. Once locked, each pocketed ball
//   is judged against the called pocket.
//
// Ports
//   clk            in   system clock
//   resetN         in   synchronous, active-low reset
//   startOfFrame   in   one-cycle pulse per video frame
//   selectEnable   in   level; game requests/holds a pocket call
//   nextKey        in   level key; advance cursor
//   prevKey        in   level key; move cursor back
//   confirmKey     in   level key; lock cursor
//   ballInHole     in   one-cycle pulse; a ball was pocketed
//   ballHoleIndex  in   [2:0] pocket of that ball, 1..6
//   holeNumber     out  [2:0] cursor/called pocket, always 1..6
//   showHoleNumber out  overlay enable (blinks while selecting)
//   holeLocked     out  high while the call is locked
//   callHit        out  one-cycle pulse; pocketed ball matched the call
//   callMiss       out  one-cycle pulse; pocketed ball missed the call
module hole_selector #(
  parameter int BLINK_FRAMES   = 15,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       selectEnable,
  input  logic       nextKey,
  input  logic       prevKey,
  input  logic       confirmKey,
  input  logic       ballInHole,
  input  logic [2:0] ballHoleIndex,
  output logic [2:0] holeNumber,
  output logic       showHoleNumber,
  output logic       holeLocked,
  output logic       callHit,
  output logic       callMiss
);

  localparam int BW = (BLINK_FRAMES   > 1) ? $clog2(BLINK_FRAMES)   : 1;
  localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, LOCKED} state_t;

  // Key bit order: 0 = next, 1 = prev, 2 = confirm.
  logic [2:0] keys;
  logic [2:0] key_sync_reg;
  logic [2:0] key_dly_reg;
  logic [2:0] key_edge;

  assign keys = {confirmKey, prevKey, nextKey};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      always_ff @(posedge clk) begin
        if (!resetN) begin
          key_sync_reg[gi] <= 1'b0;
          key_dly_reg[gi]  <= 1'b0;
        end else begin
          key_sync_reg[gi] <= keys[gi];
          key_dly_reg[gi]  <= key_sync_reg[gi];
        end
      end
      assign key_edge[gi] = key_sync_reg[gi] & ~key_dly_reg[gi];
    end
  endgenerate

  state_t        state_reg,   state_next;
  logic [2:0]    hole_reg,    hole_next;
  logic          show_reg,    show_next;
  logic          locked_reg,  locked_next;
  logic          hit_reg,     hit_next;
  logic          miss_reg,    miss_next;
  logic [BW-1:0] blink_reg,   blink_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg   <= IDLE;
      hole_reg    <= 3'd1;
      show_reg    <= 1'b0;
      locked_reg  <= 1'b0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      blink_reg   <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      hole_reg    <= hole_next;
      show_reg    <= show_next;
      locked_reg  <= locked_next;
      hit_reg     <= hit_next;
      miss_reg    <= miss_next;
      blink_reg   <= blink_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hole_next    = hole_reg;
    show_next    = show_reg;
    locked_next  = 1'b0;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    blink_next   = blink_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      IDLE: begin
        show_next = 1'b0;
        if (selectEnable) begin
          state_next   = SELECT;
          show_next    = 1'b1;
          blink_next   = '0;
          timeout_next = '0;
        end
      end

      SELECT: begin
        if (!selectEnable) begin
          state_next = IDLE;
          show_next  = 1'b0;
        end else if (key_edge[2]) begin
          // Confirm wins over a same-cycle move; the move is dropped.
          state_next  = LOCKED;
          show_next   = 1'b1;
          locked_next = 1'b1;
        end else if (key_edge[0] | key_edge[1]) begin
          // Simultaneous next+prev still counts as activity (show forced on,
          // counters restarted) but leaves the cursor where it is.
          if (key_edge[0] & ~key_edge[1])
            hole_next = (hole_reg == 3'd6) ? 3'd1 : hole_reg + 3'd1;
          else if (key_edge[1] & ~key_edge[0])
            hole_next = (hole_reg == 3'd1) ? 3'd6 : hole_reg - 3'd1;
          show_next    = 1'b1;
          blink_next   = '0;
          timeout_next = '0;
        end else if (startOfFrame) begin
          if (blink_reg == BLINK_LAST) begin
            show_next  = ~show_reg;
            blink_next = '0;
          end else begin
            blink_next = blink_reg + 1'b1;
          end
          if (timeout_reg == TIMEOUT_LAST) begin
            state_next   = LOCKED;
            show_next    = 1'b1;
            locked_next  = 1'b1;
            timeout_next = '0;
          end else begin
            timeout_next = timeout_reg + 1'b1;
          end
        end
      end

      LOCKED: begin
        show_next   = 1'b1;
        locked_next = 1'b1;
        if (!selectEnable) begin
          state_next  = IDLE;
          show_next   = 1'b0;
          locked_next = 1'b0;
        end
        // The ball is judged even on the cycle the call is being released.
        if (ballInHole) begin
          if (ballHoleIndex == hole_reg)
            hit_next = 1'b1;
          else if (ballHoleIndex >= 3'd1 && ballHoleIndex <= 3'd6)
            miss_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        show_next  = 1'b0;
      end
    endcase
  end

  assign holeNumber     = hole_reg;
  assign showHoleNumber = show_reg;
  assign holeLocked     = locked_reg;
  assign callHit        = hit_reg;
  assign callMiss       = miss_reg;

endmodule
